dlx_alu_pipe: RTL and testbench
===============================

DLX_ALU_PIPE -- requirements
Module: dlx_alu_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand width; even, >= 16.
REQ-002 SHALL have parameter TAG_WIDTH, default 4, width of the opaque tag carried with each operation.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, request valid.
REQ-006 SHALL have port in_ready, output, 1, the block accepts a request this cycle.
REQ-007 SHALL have ports aluin1 and aluin2, input, DATA_WIDTH each, signed operands.
REQ-008 SHALL have ports aluopselect and aluoperation, input, 3 each: opcode group and operation.
REQ-009 SHALL have port in_tag, input, TAG_WIDTH, returned unchanged with the result.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-012 SHALL have port aluout, output, DATA_WIDTH+1; bit DATA_WIDTH is carry/borrow.
REQ-013 SHALL have port out_tag, output, TAG_WIDTH.
REQ-014 SHALL have ports out_zero, out_ovf and out_err, output, 1 each, status flags.

Function
REQ-015 SHALL accept a request on in_valid && in_ready; outputs for it are presented exactly 2 cycles later if out_ready has remained high.
REQ-016 SHALL implement 2 registered stages. S1 registers operands, op and tag. S2 registers result, flags and tag.
REQ-017 SHALL advance S2 when !s2_valid || out_ready, and S1 when !s1_valid || S2 advances; in_ready SHALL equal the S1 advance condition, so full throughput is one op per cycle.
REQ-018 SHALL hold aluout, out_tag and all flags stable while out_valid && !out_ready; no request is dropped or duplicated.
REQ-019 SHALL implement group 001 (arith/logic), with N = DATA_WIDTH and H = N/2:
- 000 ADD: N+1-bit sum.
- 001 HADD: H-bit add of the low halves, sign-extended to N bits; carry in bit N.
- 010 SUB: aluin1 - aluin2; borrow in bit N.
- 011 NOT: ~aluin2.
- 100 AND, 101 OR, 110 XOR.
- 111 LHG: {aluin2[H-1:0], H zeros}.
- For NOT, AND, OR, XOR and LHG, bit N SHALL be 0.
REQ-020 SHALL implement group 101 (load-extend) from aluin2, with bit N = 0:
- 000 sign-extended byte; 100 zero-extended byte.
- 001 sign-extended half; 101 zero-extended half.
- 011 full word.
- Codes 010, 110 and 111 SHALL produce 0 with out_err = 1.
REQ-021 SHALL produce aluout = 0 and out_err = 1 for any unsupported group.
REQ-022 SHALL set out_ovf = 1 only for ADD or SUB with signed N-bit overflow; otherwise 0.
REQ-023 SHALL set out_zero = 1 when aluout[N-1:0] == 0.

Reset
REQ-024 SHALL, on reset low, asynchronously clear all valid bits, aluout, out_tag and all flags; in_ready SHALL be 1 while reset is low and after release.
REQ-025 SHALL discard in-flight operations when reset is asserted mid-operation; no result for them is ever presented.

Configuration
REQ-026 SHALL, with macro DLX_ALU_SHIFT_EN defined, implement group 000, with shift amount aluin2[log2(N)-1:0] and bit N = 0:
- 000 SLL, 001 SRL, 010 SRA.
- Other codes SHALL produce 0 with out_err = 1.
REQ-027 SHALL, without DLX_ALU_SHIFT_EN, treat group 000 as unsupported per REQ-021, and contain no shifter logic.

Verification
REQ-028 SHALL cover ADD with 0x7FFFFFFF + 0x00000001, N=32 -> aluout = 0x0_80000000, out_ovf = 1, out_zero = 0, exactly 2 cycles after acceptance.
REQ-029 SHALL cover SUB with 0 - 1 -> aluout = 0x1_FFFFFFFF, out_ovf = 0; HADD with 0x0000FFFF + 0x00000001 -> 0x1_00000000, out_zero = 1.
REQ-030 SHALL cover back-to-back tags 1..8, with out_ready low for 3 cycles mid-stream -> all 8 results in order, held stable while stalled, and in_ready low while both stages are full.
REQ-031 SHALL cover load-extend 101/000 with aluin2 = 0x00000080 -> 0x0_FFFFFF80; 101/100 -> 0x0_00000080; 101/010 -> 0, out_err = 1.
REQ-032 SHALL cover SRA 0x80000000 by 4 -> 0x0_F8000000 with DLX_ALU_SHIFT_EN defined; the same stimulus without the macro -> 0, out_err = 1.
REQ-033 SHALL cover reset asserted with 2 operations in flight -> out_valid = 0 immediately, and no stale result appears after release.

Source files
------------

// File: rtl/dlx_alu_pipe.sv
// dlx_alu_pipe: two-stage pipelined DLX ALU with a valid/ready handshake on
// both sides. S1 captures the operands, opcode and tag; S2 captures the
// result, the status flags and the tag. An S2 result is held until the
// consumer takes it, and back-pressure propagates to in_ready.
//
// Optional feature: define DLX_ALU_SHIFT_EN to enable the shift group (000).
// Without the macro, group 000 is reported as unsupported and no shifter is built.
module dlx_alu_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] aluin1,
    input  logic signed [DATA_WIDTH-1:0] aluin2,
    input  logic [2:0]                   aluopselect,
    input  logic [2:0]                   aluoperation,
    input  logic [TAG_WIDTH-1:0]         in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH:0]          aluout,
    output logic [TAG_WIDTH-1:0]         out_tag,
    output logic                         out_zero,
    output logic                         out_ovf,
    output logic                         out_err
);

    localparam int N = DATA_WIDTH;
    localparam int H = DATA_WIDTH / 2;

    localparam logic [2:0] GRP_SHIFT = 3'b000;
    localparam logic [2:0] GRP_ALU   = 3'b001;
    localparam logic [2:0] GRP_LOAD  = 3'b101;

    // Signed overflow of an N-bit add: same-sign operands, result sign differs.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    // Signed overflow of an N-bit subtract: operand signs differ, result sign
    // differs from the minuend.
    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    // Stage 1 state
    logic                vld_p1;
    logic signed [N-1:0] a_p1;
    logic signed [N-1:0] b_p1;
    logic [2:0]          grp_p1;
    logic [2:0]          op_p1;
    logic [TAG_WIDTH-1:0] tag_p1;

    // Stage 2 state
    logic                 vld_p2;
    logic [N:0]           res_p2;
    logic [TAG_WIDTH-1:0] tag_p2;
    logic                 zero_p2;
    logic                 ovf_p2;
    logic                 err_p2;

    logic adv_p1;
    logic adv_p2;

    // Combinational result of the operation held in S1
    logic [N:0] sum_c;
    logic [N:0] diff_c;
    logic [H:0] hsum_c;
    logic [N:0] res_c;
    logic       ovf_c;
    logic       err_c;

    // S2 drains when empty or when the consumer takes the result; S1 moves
    // whenever it is empty or S2 is making room.
    assign adv_p2   = !vld_p2 || out_ready;
    assign adv_p1   = !vld_p1 || adv_p2;
    assign in_ready = adv_p1;

    // Zero-extended operands make bit N the carry (add) or borrow (subtract).
    assign sum_c  = {1'b0, a_p1} + {1'b0, b_p1};
    assign diff_c = {1'b0, a_p1} - {1'b0, b_p1};
    assign hsum_c = {1'b0, a_p1[H-1:0]} + {1'b0, b_p1[H-1:0]};

`ifdef DLX_ALU_SHIFT_EN
    localparam int SHW = $clog2(N);
    logic [SHW-1:0]      shamt_c;
    logic signed [N-1:0] sra_c;
    assign shamt_c = b_p1[SHW-1:0];
    assign sra_c   = a_p1 >>> shamt_c;
`endif

    // Decode the S1 operation into result, overflow and error status
    always_comb begin
        res_c = '0;
        ovf_c = 1'b0;
        err_c = 1'b0;
        case (grp_p1)
            GRP_ALU: begin
                case (op_p1)
                    3'b000: begin
                        res_c = sum_c;
                        ovf_c = add_ovf(a_p1[N-1], b_p1[N-1], sum_c[N-1]);
                    end
                    3'b001: res_c = {hsum_c[H], N'(signed'(hsum_c[H-1:0]))};
                    3'b010: begin
                        res_c = diff_c;
                        ovf_c = sub_ovf(a_p1[N-1], b_p1[N-1], diff_c[N-1]);
                    end
                    3'b011:  res_c = {1'b0, ~b_p1};
                    3'b100:  res_c = {1'b0, a_p1 & b_p1};
                    3'b101:  res_c = {1'b0, a_p1 | b_p1};
                    3'b110:  res_c = {1'b0, a_p1 ^ b_p1};
                    default: res_c = {1'b0, b_p1[H-1:0], {H{1'b0}}};
                endcase
            end
            GRP_LOAD: begin
                case (op_p1)
                    3'b000:  res_c = {1'b0, N'(signed'(b_p1[7:0]))};
                    3'b100:  res_c = {1'b0, N'(b_p1[7:0])};
                    3'b001:  res_c = {1'b0, N'(signed'(b_p1[15:0]))};
                    3'b101:  res_c = {1'b0, N'(b_p1[15:0])};
                    3'b011:  res_c = {1'b0, b_p1};
                    default: err_c = 1'b1;
                endcase
            end
`ifdef DLX_ALU_SHIFT_EN
            GRP_SHIFT: begin
                case (op_p1)
                    3'b000:  res_c = {1'b0, a_p1 << shamt_c};
                    3'b001:  res_c = {1'b0, a_p1 >> shamt_c};
                    3'b010:  res_c = {1'b0, sra_c};
                    default: err_c = 1'b1;
                endcase
            end
`endif
            default: err_c = 1'b1;
        endcase
    end

    // S1 valid: load on every advance so a bubble is taken when in_valid is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
        end else if (adv_p1) begin
            vld_p1 <= in_valid;
        end
    end

    // S1 payload: captured only for an accepted request
    always_ff @(posedge clk) begin
        if (adv_p1 && in_valid) begin
            a_p1   <= aluin1;
            b_p1   <= aluin2;
            grp_p1 <= aluopselect;
            op_p1  <= aluoperation;
            tag_p1 <= in_tag;
        end
    end

    // S2: result and flags; everything holds while the consumer stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p2  <= 1'b0;
            res_p2  <= '0;
            tag_p2  <= '0;
            zero_p2 <= 1'b0;
            ovf_p2  <= 1'b0;
            err_p2  <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                res_p2  <= res_c;
                tag_p2  <= tag_p1;
                zero_p2 <= (res_c[N-1:0] == '0);
                ovf_p2  <= ovf_c;
                err_p2  <= err_c;
            end
        end
    end

    assign out_valid = vld_p2;
    assign aluout    = res_p2;
    assign out_tag   = tag_p2;
    assign out_zero  = zero_p2;
    assign out_ovf   = ovf_p2;
    assign out_err   = err_p2;

endmodule

// File: tb/tb_dlx_alu_pipe.sv
// Testbench for dlx_alu_pipe (DATA_WIDTH=32, TAG_WIDTH=4). Directed vectors
// with hand-computed results are queued as they are issued; an independent
// monitor checks every presented output against the head of the queue and
// retires it on the handshake. Honours DLX_ALU_SHIFT_EN for the shift group.
`timescale 1ns/100ps
module tb_dlx_alu_pipe;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] aluin1;
    logic signed [31:0] aluin2;
    logic [2:0]         aluopselect;
    logic [2:0]         aluoperation;
    logic [3:0]         in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [32:0]        aluout;
    logic [3:0]         out_tag;
    logic               out_zero;
    logic               out_ovf;
    logic               out_err;

    dlx_alu_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .aluin1(aluin1), .aluin2(aluin2),
        .aluopselect(aluopselect), .aluoperation(aluoperation),
        .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluout(aluout), .out_tag(out_tag),
        .out_zero(out_zero), .out_ovf(out_ovf), .out_err(out_err)
    );

    typedef struct {
        string       nm;
        logic [39:0] v;
        int          exp_cyc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [39:0] pack(input logic [32:0] r, input logic [3:0] t,
                                         input logic z, input logic o, input logic e);
        return {r, t, z, o, e};
    endfunction

    // Monitor: compare every presented output to the queue head; retire on handshake
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got aluout=%h tag=%h", aluout, out_tag);
                end else begin
                    chk(q[0].nm, 64'(pack(aluout, out_tag, out_zero, out_ovf, out_err)), 64'(q[0].v));
                    if (out_ready) begin
                        if (q[0].lat)
                            chk({q[0].nm, "_latency"}, 64'(cyc), 64'(q[0].exp_cyc));
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input string nm, input logic [2:0] g, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [3:0] tg,
                        input logic [32:0] r, input logic o, input logic e, input bit lat);
        exp_t x;
        int   w;
        @(negedge clk);
        #1;
        aluopselect  = g;
        aluoperation = op;
        aluin1       = a;
        aluin2       = b;
        in_tag       = tg;
        in_valid     = 1'b1;
        #0.5;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            #1.5;
            w++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_accept_timeout: in_ready=%b expected 1", nm, in_ready);
        end else begin
            x.nm      = nm;
            x.v       = pack(r, tg, (r[31:0] == 32'h0), o, e);
            x.exp_cyc = cyc + 2;
            x.lat     = lat;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int w;
        w = 0;
        while (q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        #3;
        chk({nm, "_drained"}, 64'(q.size()), 64'd0);
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        reset        = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        aluin1       = '0;
        aluin2       = '0;
        aluopselect  = '0;
        aluoperation = '0;
        in_tag       = '0;
        #1 reset = 1'b0;

        // Reset state
        #11;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_outputs", 64'(pack(aluout, out_tag, out_zero, out_ovf, out_err)), 64'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        #0.5;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Arith/logic group
        send("add_ovf",   3'b001, 3'b000, 32'h7FFFFFFF, 32'h00000001, 4'h1, 33'h0_80000000, 1'b1, 1'b0, 1'b1);
        drain("add_ovf");
        send("sub_borrow", 3'b001, 3'b010, 32'h00000000, 32'h00000001, 4'h2, 33'h1_FFFFFFFF, 1'b0, 1'b0, 1'b0);
        send("hadd_carry", 3'b001, 3'b001, 32'h0000FFFF, 32'h00000001, 4'h3, 33'h1_00000000, 1'b0, 1'b0, 1'b0);
        send("hadd_sext",  3'b001, 3'b001, 32'h00007FFF, 32'h00000001, 4'h4, 33'h0_FFFF8000, 1'b0, 1'b0, 1'b0);
        send("add_carry",  3'b001, 3'b000, 32'hFFFFFFFF, 32'h00000001, 4'h5, 33'h1_00000000, 1'b0, 1'b0, 1'b0);
        send("sub_ovf",    3'b001, 3'b010, 32'h80000000, 32'h00000001, 4'h6, 33'h0_7FFFFFFF, 1'b1, 1'b0, 1'b0);
        send("not",        3'b001, 3'b011, 32'h12345678, 32'h0F0F0F0F, 4'h7, 33'h0_F0F0F0F0, 1'b0, 1'b0, 1'b0);
        send("and",        3'b001, 3'b100, 32'h12345678, 32'h0F0F0F0F, 4'h8, 33'h0_02040608, 1'b0, 1'b0, 1'b0);
        send("or",         3'b001, 3'b101, 32'h12345678, 32'h0F0F0F0F, 4'h9, 33'h0_1F3F5F7F, 1'b0, 1'b0, 1'b0);
        send("xor",        3'b001, 3'b110, 32'h12345678, 32'h0F0F0F0F, 4'hA, 33'h0_1D3B5977, 1'b0, 1'b0, 1'b0);
        send("lhg",        3'b001, 3'b111, 32'h00000000, 32'h1234ABCD, 4'hB, 33'h0_ABCD0000, 1'b0, 1'b0, 1'b0);
        drain("alu");

        // Load-extend group and unsupported groups
        send("ld_sbyte",  3'b101, 3'b000, 32'h0, 32'h00000080, 4'h1, 33'h0_FFFFFF80, 1'b0, 1'b0, 1'b0);
        send("ld_zbyte",  3'b101, 3'b100, 32'h0, 32'h00000080, 4'h2, 33'h0_00000080, 1'b0, 1'b0, 1'b0);
        send("ld_bad010", 3'b101, 3'b010, 32'h0, 32'h00000080, 4'h3, 33'h0_00000000, 1'b0, 1'b1, 1'b0);
        send("ld_shalf",  3'b101, 3'b001, 32'h0, 32'h00008001, 4'h4, 33'h0_FFFF8001, 1'b0, 1'b0, 1'b0);
        send("ld_zhalf",  3'b101, 3'b101, 32'h0, 32'h00008001, 4'h5, 33'h0_00008001, 1'b0, 1'b0, 1'b0);
        send("ld_word",   3'b101, 3'b011, 32'h0, 32'hDEADBEEF, 4'h6, 33'h0_DEADBEEF, 1'b0, 1'b0, 1'b0);
        send("ld_bad111", 3'b101, 3'b111, 32'h0, 32'hDEADBEEF, 4'h7, 33'h0_00000000, 1'b0, 1'b1, 1'b0);
        send("grp_111",   3'b111, 3'b000, 32'h7FFFFFFF, 32'h1, 4'h8, 33'h0_00000000, 1'b0, 1'b1, 1'b0);
`ifdef DLX_ALU_SHIFT_EN
        send("sra",     3'b000, 3'b010, 32'h80000000, 32'h00000004, 4'h9, 33'h0_F8000000, 1'b0, 1'b0, 1'b0);
        send("srl",     3'b000, 3'b001, 32'h80000000, 32'h00000004, 4'hA, 33'h0_08000000, 1'b0, 1'b0, 1'b0);
        send("sll",     3'b000, 3'b000, 32'h00000001, 32'h0000001F, 4'hB, 33'h0_80000000, 1'b0, 1'b0, 1'b0);
        send("sh_bad",  3'b000, 3'b011, 32'h00000001, 32'h00000001, 4'hC, 33'h0_00000000, 1'b0, 1'b1, 1'b0);
`else
        send("sra_off", 3'b000, 3'b010, 32'h80000000, 32'h00000004, 4'h9, 33'h0_00000000, 1'b0, 1'b1, 1'b0);
        send("sll_off", 3'b000, 3'b000, 32'h00000001, 32'h0000001F, 4'hA, 33'h0_00000000, 1'b0, 1'b1, 1'b0);
`endif
        drain("load");

        // Back-to-back tags 1..8 with a 3-cycle consumer stall mid-stream
        sent = 1;
        for (int k = 0; k < 40 && sent <= 8; k++) begin
            exp_t x;
            @(negedge clk);
            #1;
            out_ready    = !(k >= 4 && k <= 6);
            in_valid     = 1'b1;
            aluopselect  = 3'b001;
            aluoperation = 3'b000;
            aluin1       = 32'(sent * 256);
            aluin2       = 32'(sent);
            in_tag       = 4'(sent);
            #0.5;
            if (k <= 6)
                chk($sformatf("b2b_in_ready_k%0d", k), 64'(in_ready), (k >= 4) ? 64'd0 : 64'd1);
            if (in_ready) begin
                x.nm      = $sformatf("b2b_tag%0d", sent);
                x.v       = pack(33'(sent * 257), 4'(sent), 1'b0, 1'b0, 1'b0);
                x.exp_cyc = 0;
                x.lat     = 1'b0;
                q.push_back(x);
                sent++;
            end
        end
        chk("b2b_all_issued", 64'(sent), 64'd9);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("b2b");

        // Reset with two operations in flight
        @(negedge clk);
        #1;
        aluopselect = 3'b001; aluoperation = 3'b000;
        aluin1 = 32'd1; aluin2 = 32'd2; in_tag = 4'h9; in_valid = 1'b1;
        @(negedge clk);
        #1;
        aluin1 = 32'd3; aluin2 = 32'd4; in_tag = 4'hA;
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        chk("inflight_out_valid", 64'(out_valid), 64'd1);
        q.delete();
        reset = 1'b0;
        #0.5;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_outputs", 64'(pack(aluout, out_tag, out_zero, out_ovf, out_err)), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("postrst_no_stale_%0d", k), 64'(out_valid), 64'd0);
        end

        // Pipeline still works after the mid-flight reset
        send("post_rst_add", 3'b001, 3'b000, 32'h00000005, 32'h00000007, 4'hF, 33'h0_0000000C, 1'b0, 1'b0, 1'b1);
        drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
